versa_ekey_writer: RTL

//  Trusted engine that is the only writer of the ephemeral-key (EKEY) region.
//  - REFRESH: fills EKEY with fresh bytes from an entropy source.
//  - ERASE: zeroes EKEY.

---
 rtl/versa_ekey_writer_pkg.sv | 11 +
 rtl/versa_ekey_writer_if.sv | 12 +
 rtl/versa_ekey_writer.sv | 74 +++++++
 3 files changed

// File: rtl/versa_ekey_writer_pkg.sv
// versa_ekey_writer_pkg: EKEY region geometry, engine state encoding and operation mode
package versa_ekey_writer_pkg;
  localparam logic [15:0] EKEY_BASE = 16'h0230;
  localparam logic [15:0] EKEY_SIZE = 16'h001F;
  localparam logic [4:0] LAST_IDX = 5'(EKEY_SIZE - 16'd1);
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WRITE, ST_FIN} state_t;
  typedef enum logic {MODE_REFRESH, MODE_ERASE} mode_t;
  function automatic logic [15:0] ekey_addr(input logic [4:0] idx);
    return EKEY_BASE + {11'b0, idx};
  endfunction
endpackage

// File: rtl/versa_ekey_writer_if.sv
// versa_ekey_writer_if: entropy source handshake plus granted memory write port
interface versa_ekey_writer_if;
  logic        ent_valid;
  logic        ent_ready;
  logic [7:0]  ent_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  modport master(input ent_valid, ent_data, wr_gnt, output ent_ready, wr_req, wr_addr, wr_data);
  modport slave(output ent_valid, ent_data, wr_gnt, input ent_ready, wr_req, wr_addr, wr_data);
endinterface

// File: rtl/versa_ekey_writer.sv
// versa_ekey_writer: sole writer of the EKEY region, refreshing it from entropy or erasing it
module versa_ekey_writer
  import versa_ekey_writer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic refresh_req,
  input  logic erase_req,
  versa_ekey_writer_if.master bus,
  output logic busy,
  output logic done,
  output logic key_valid
);
  state_t state, state_n;
  mode_t mode, mode_n;
  logic [4:0] idx, idx_n;
  logic [7:0] byte_q;
  logic kv_n, last, abort;
  assign last = idx == LAST_IDX;
  // an erase arriving mid-refresh restarts the region from its first byte
  assign abort = erase_req && mode == MODE_REFRESH && (state == ST_FETCH || state == ST_WRITE);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mode <= MODE_REFRESH;
      idx <= '0;
      byte_q <= '0;
      key_valid <= 1'b0;
    end else begin
      state <= state_n;
      mode <= mode_n;
      idx <= idx_n;
      key_valid <= kv_n;
      if (state == ST_FETCH && bus.ent_valid) byte_q <= bus.ent_data;
    end
  end
  always_comb begin
    state_n = state;
    mode_n = mode;
    idx_n = idx;
    kv_n = key_valid;
    case (state)
      ST_IDLE: if (erase_req || refresh_req) begin
        state_n = erase_req ? ST_WRITE : ST_FETCH;
        mode_n = erase_req ? MODE_ERASE : MODE_REFRESH;
        idx_n = '0;
        kv_n = 1'b0;
      end
      ST_FETCH: state_n = bus.ent_valid ? ST_WRITE : ST_FETCH;
      ST_WRITE: if (bus.wr_gnt) begin
        state_n = last ? ST_FIN : (mode == MODE_REFRESH ? ST_FETCH : ST_WRITE);
        idx_n = last ? idx : idx + 5'd1;
      end
      default: begin
        state_n = ST_IDLE;
        kv_n = mode == MODE_REFRESH;
      end
    endcase
    if (abort) begin
      state_n = ST_WRITE;
      mode_n = MODE_ERASE;
      idx_n = '0;
      kv_n = 1'b0;
    end
  end
  always_comb begin
    bus.ent_ready = state == ST_FETCH;
    bus.wr_req = state == ST_WRITE;
    bus.wr_addr = state == ST_WRITE ? ekey_addr(idx) : 16'h0000;
    bus.wr_data = (state == ST_WRITE && mode == MODE_REFRESH) ? byte_q : 8'h00;
    busy = state != ST_IDLE;
    done = state == ST_FIN;
  end
endmodule
